// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of one shared multi-cycle memory port.
// The instruction (imem) and data (dmem) requesters compete for the port.
// A tie in IDLE is broken round-robin against the last requester served.
// The winner's request is latched on the grant edge, so the memory sees a
// stable request for the whole transaction. Response and read data go back
// combinationally to the granted requester only.
module mem_port_arbiter #(
  parameter bit DMEM_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,

  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,

  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,

  output logic        grant_dmem
);

  typedef enum logic [1:0] {StIdle, StIBusy, StDBusy} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [3:0]  rmask_q;
  logic [3:0]  wmask_q;
  logic [31:0] wdata_q;
  // 1 when dmem was the last requester served. The reset value makes
  // DMEM_FIRST win the first tie.
  logic        last_dmem_q;

  logic i_pend;
  logic d_pend;
  logic pick_dmem;

  assign i_pend = (imem_rmask != 4'h0);
  assign d_pend = ((dmem_rmask | dmem_wmask) != 4'h0);

  // dmem wins when it is alone, or when both are pending and imem went last.
  assign pick_dmem = d_pend && (!i_pend || !last_dmem_q);

  // Arbitration FSM. The captured request and the memory masks are registered here.
  // The masks are nonzero only while busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= 32'h0;
      rmask_q     <= 4'h0;
      wmask_q     <= 4'h0;
      wdata_q     <= 32'h0;
      last_dmem_q <= ~DMEM_FIRST;
    end else begin
      unique case (state_q)
        StIdle: begin
          // mem_resp is ignored here; a response only counts while busy.
          if (pick_dmem) begin
            state_q <= StDBusy;
            addr_q  <= dmem_addr;
            rmask_q <= dmem_rmask;
            wmask_q <= dmem_wmask;
            wdata_q <= dmem_wdata;
          end else if (i_pend) begin
            state_q <= StIBusy;
            addr_q  <= imem_addr;
            rmask_q <= imem_rmask;
            wmask_q <= 4'h0;
            wdata_q <= 32'h0;
          end
        end
        StIBusy: begin
          if (mem_resp) begin
            state_q     <= StIdle;
            rmask_q     <= 4'h0;
            wmask_q     <= 4'h0;
            last_dmem_q <= 1'b0;
          end
        end
        StDBusy: begin
          if (mem_resp) begin
            state_q     <= StIdle;
            rmask_q     <= 4'h0;
            wmask_q     <= 4'h0;
            last_dmem_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          rmask_q <= 4'h0;
          wmask_q <= 4'h0;
        end
      endcase
    end
  end

  // Address and write data hold their last value in IDLE. Only the masks mark a live request.
  assign mem_addr   = addr_q;
  assign mem_rmask  = rmask_q;
  assign mem_wmask  = wmask_q;
  assign mem_wdata  = wdata_q;
  assign grant_dmem = (state_q == StDBusy);

  // Route the memory response to the granted requester only. The other side reads zero.
  always_comb begin
    imem_resp  = 1'b0;
    imem_rdata = 32'h0;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    if (state_q == StIBusy) begin
      imem_resp  = mem_resp;
      imem_rdata = mem_rdata;
    end else if (state_q == StDBusy) begin
      dmem_resp  = mem_resp;
      dmem_rdata = mem_rdata;
    end
  end

endmodule
